// File: rtl/sram_pmu_idle_ctrl.sv
// Idle-driven power request generator for the SRAM controller PMU port.
// Requests save after a programmable idle period and restore on activity, wake or disable.
module sram_pmu_idle_ctrl #(
   parameter int unsigned IDLE_W      = 8,
   parameter int unsigned ACK_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              hclk,
   input  logic              hreset_n,
   input  logic              enable,
   input  logic [IDLE_W-1:0] idle_limit,
   input  logic              hsel,
   input  logic [1:0]        htrans,
   input  logic              wake_req,
   input  logic [1:0]        fsm_state,
   output logic              pwr_save_req,
   output logic              pwr_restore_req,
   output logic [1:0]        pmu_state,
   output logic              handshake_err,
   output logic [CNT_W-1:0]  sleep_entries
);

   localparam int unsigned    ToW    = $clog2(ACK_TIMEOUT);
   localparam logic [ToW-1:0] ToLast = ToW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      StRun        = 2'b00,
      StSaveReq    = 2'b01,
      StAsleep     = 2'b10,
      StRestoreReq = 2'b11
   } state_e;

   state_e             state_q, state_d;
   logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
   logic [ToW-1:0]     to_cnt_q, to_cnt_d;
   logic               wake_pend_q, wake_pend_d;
   logic               save_q, save_d;
   logic               restore_q, restore_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   entries_q, entries_d;

   logic activity;
   logic wake_cond;
   logic unused_htrans;

   // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY do not.
   assign activity      = hsel & htrans[1];
   assign wake_cond     = activity | wake_req | ~enable;
   assign unused_htrans = htrans[0];

   always_comb begin
      state_d     = state_q;
      idle_cnt_d  = idle_cnt_q;
      to_cnt_d    = '0;
      wake_pend_d = wake_pend_q;
      err_d       = 1'b0;
      entries_d   = entries_q;

      unique case (state_q)
         StRun: begin
            if (activity || !enable || (idle_limit == '0)) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q == (idle_limit - IDLE_W'(1))) begin
               state_d    = StSaveReq;
               idle_cnt_d = '0;
            end else if (idle_cnt_q != '1) begin
               idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
         end
         StSaveReq: begin
            to_cnt_d    = to_cnt_q + ToW'(1);
            wake_pend_d = wake_pend_q | wake_cond;
            if (fsm_state == 2'b01) begin
               state_d = StAsleep;
               if (entries_q != '1) begin
                  entries_d = entries_q + CNT_W'(1);
               end
            end else if (to_cnt_q == ToLast) begin
               state_d     = StRun;
               err_d       = 1'b1;
               wake_pend_d = 1'b0;
               idle_cnt_d  = '0;
            end
         end
         StAsleep: begin
            if (wake_pend_q || wake_cond) begin
               state_d     = StRestoreReq;
               wake_pend_d = 1'b0;
            end
         end
         StRestoreReq: begin
            to_cnt_d = to_cnt_q + ToW'(1);
            // WAKEUP (10) is still in progress and does not count as an ack.
            if (fsm_state == 2'b00) begin
               state_d    = StRun;
               idle_cnt_d = '0;
            end else if (to_cnt_q == ToLast) begin
               state_d     = StAsleep;
               err_d       = 1'b1;
               wake_pend_d = 1'b1;
            end
         end
         default: state_d = StRun;
      endcase

      if (state_d != state_q) begin
         to_cnt_d = '0;
      end

      save_d    = (state_d == StSaveReq);
      restore_d = (state_d == StRestoreReq);
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q     <= StRun;
         idle_cnt_q  <= '0;
         to_cnt_q    <= '0;
         wake_pend_q <= 1'b0;
         save_q      <= 1'b0;
         restore_q   <= 1'b0;
         err_q       <= 1'b0;
         entries_q   <= '0;
      end else begin
         state_q     <= state_d;
         idle_cnt_q  <= idle_cnt_d;
         to_cnt_q    <= to_cnt_d;
         wake_pend_q <= wake_pend_d;
         save_q      <= save_d;
         restore_q   <= restore_d;
         err_q       <= err_d;
         entries_q   <= entries_d;
      end
   end

   assign pwr_save_req    = save_q;
   assign pwr_restore_req = restore_q;
   assign pmu_state       = state_q;
   assign handshake_err   = err_q;
   assign sleep_entries   = entries_q;

endmodule

// File: tb/tb_sram_pmu_idle_ctrl.sv
// Bench for sram_pmu_idle_ctrl: vector table, directed corner sequences and a random run
// compared cycle by cycle against a behavioural model of the power-request rules.
module tb_sram_pmu_idle_ctrl;

   localparam int unsigned IDLE_W      = 8;
   localparam int unsigned ACK_TIMEOUT = 8;
   localparam int unsigned CNT_W       = 4;
   localparam int          ENT_MAX     = (1 << CNT_W) - 1;

   logic              hclk = 1'b0;
   logic              hreset_n = 1'b0;
   logic              enable = 1'b0;
   logic [IDLE_W-1:0] idle_limit = '0;
   logic              hsel = 1'b0;
   logic [1:0]        htrans = 2'b00;
   logic              wake_req = 1'b0;
   logic [1:0]        fsm_state = 2'b00;
   logic              pwr_save_req;
   logic              pwr_restore_req;
   logic [1:0]        pmu_state;
   logic              handshake_err;
   logic [CNT_W-1:0]  sleep_entries;

   sram_pmu_idle_ctrl #(
      .IDLE_W      (IDLE_W),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .hclk            (hclk),
      .hreset_n        (hreset_n),
      .enable          (enable),
      .idle_limit      (idle_limit),
      .hsel            (hsel),
      .htrans          (htrans),
      .wake_req        (wake_req),
      .fsm_state       (fsm_state),
      .pwr_save_req    (pwr_save_req),
      .pwr_restore_req (pwr_restore_req),
      .pmu_state       (pmu_state),
      .handshake_err   (handshake_err),
      .sleep_entries   (sleep_entries)
   );

   always #5 hclk = ~hclk;

   int total = 0;
   int bad   = 0;

   // Model: mode uses the published pmu_state meaning (0 run, 1 save, 2 asleep, 3 restore).
   int m_mode, m_idle, m_wait, m_entries;
   bit m_pend, m_err;

   typedef struct {
      logic       hsel;
      logic [1:0] htrans;
      logic       wake;
      logic       en;
      logic [1:0] fsm;
      logic       save;
      logic       rest;
      logic [1:0] st;
      logic       err;
      int         ent;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_idle = 0; m_wait = 0; m_entries = 0; m_pend = 0; m_err = 0;
   endtask

   task automatic model_step();
      bit act, wk;
      act = hsel && htrans[1];
      wk  = act || wake_req || !enable;
      m_err = 0;
      case (m_mode)
         0: begin
            if (act || !enable || idle_limit == 0) m_idle = 0;
            else begin
               m_idle++;
               if (m_idle >= int'(idle_limit)) begin m_mode = 1; m_wait = 0; m_idle = 0; end
            end
         end
         1: begin
            m_wait++;
            m_pend = m_pend || wk;
            if (fsm_state == 2'b01) begin
               m_mode = 2;
               if (m_entries < ENT_MAX) m_entries++;
            end else if (m_wait == ACK_TIMEOUT) begin
               m_mode = 0; m_err = 1; m_pend = 0; m_idle = 0;
            end
         end
         2: begin
            if (m_pend || wk) begin m_mode = 3; m_pend = 0; m_wait = 0; end
         end
         default: begin
            m_wait++;
            if (fsm_state == 2'b00) begin
               m_mode = 0; m_idle = 0;
            end else if (m_wait == ACK_TIMEOUT) begin
               m_mode = 2; m_err = 1; m_pend = 1;
            end
         end
      endcase
   endtask

   task automatic cycle();
      @(posedge hclk);
      model_step();
      #1;
      chk("m_save", 32'(pwr_save_req), 32'(m_mode == 1));
      chk("m_rest", 32'(pwr_restore_req), 32'(m_mode == 3));
      chk("m_state", 32'(pmu_state), 32'(m_mode));
      chk("m_err", 32'(handshake_err), 32'(m_err));
      chk("m_ent", 32'(sleep_entries), 32'(m_entries));
      chk("excl", 32'(pwr_save_req & pwr_restore_req), 32'd0);
   endtask

   task automatic set_in(input logic s, input logic [1:0] t, input logic w, input logic e,
                         input logic [1:0] f);
      hsel = s; htrans = t; wake_req = w; enable = e; fsm_state = f;
   endtask

   task automatic apply_reset();
      #3 hreset_n = 1'b0;
      #1;
      chk("rst_save", 32'(pwr_save_req), 32'd0);
      chk("rst_rest", 32'(pwr_restore_req), 32'd0);
      chk("rst_state", 32'(pmu_state), 32'd0);
      chk("rst_err", 32'(handshake_err), 32'd0);
      chk("rst_ent", 32'(sleep_entries), 32'd0);
      model_reset();
      set_in(1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
      @(negedge hclk);
      hreset_n = 1'b1;
   endtask

   // From reset with idle_limit 2: two idle cycles reach SAVE_REQ, an ack reaches ASLEEP.
   task automatic reach_asleep();
      idle_limit = 8'd2;
      set_in(1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
      repeat (2) cycle();
      chk("ra_save", 32'(pwr_save_req), 32'd1);
      set_in(1'b0, 2'b00, 1'b0, 1'b1, 2'b01);
      cycle();
      chk("ra_state", 32'(pmu_state), 32'd2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // {hsel, htrans, wake, en, fsm} -> {save, restore, pmu_state, err, entries}
      tbl[0]  = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 0};
      tbl[1]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 0};
      tbl[2]  = '{1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 0};
      tbl[3]  = '{1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 0};
      tbl[4]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd1, 1'b0, 0};
      tbl[5]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd1, 1'b0, 0};
      tbl[6]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'd2, 1'b0, 1};
      tbl[7]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'd2, 1'b0, 1};
      tbl[8]  = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 2'd3, 1'b0, 1};
      tbl[9]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'd3, 1'b0, 1};
      tbl[10] = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'd3, 1'b0, 1};
      tbl[11] = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'd3, 1'b0, 1};
      tbl[12] = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1};
      tbl[13] = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1};

      model_reset();
      #12;
      apply_reset();

      // Idle threshold, save ack, activity wake, WAKEUP not an ack.
      idle_limit = 8'd4;
      for (int i = 0; i < 14; i++) begin
         set_in(tbl[i].hsel, tbl[i].htrans, tbl[i].wake, tbl[i].en, tbl[i].fsm);
         cycle();
         chk("t_save", 32'(pwr_save_req), 32'(tbl[i].save));
         chk("t_rest", 32'(pwr_restore_req), 32'(tbl[i].rest));
         chk("t_state", 32'(pmu_state), 32'(tbl[i].st));
         chk("t_err", 32'(handshake_err), 32'(tbl[i].err));
         chk("t_ent", 32'(sleep_entries), 32'(tbl[i].ent));
      end

      // Activity in the threshold cycle wins.
      apply_reset();
      idle_limit = 8'd3;
      set_in(1'b1, 2'b10, 1'b0, 1'b1, 2'b00);
      cycle();
      set_in(1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
      repeat (2) cycle();
      set_in(1'b1, 2'b10, 1'b0, 1'b1, 2'b00);
      cycle();
      chk("race_nosave", 32'(pwr_save_req), 32'd0);
      set_in(1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("race_after", 32'(pwr_save_req), 32'(i == 2));
      end

      // Wake during save: one ASLEEP cycle, then restore.
      apply_reset();
      idle_limit = 8'd2;
      repeat (2) cycle();
      set_in(1'b0, 2'b00, 1'b1, 1'b1, 2'b00);
      cycle();
      chk("wds_held", 32'(pwr_save_req), 32'd1);
      set_in(1'b0, 2'b00, 1'b0, 1'b1, 2'b01);
      cycle();
      chk("wds_asleep", 32'(pmu_state), 32'd2);
      cycle();
      chk("wds_restore", 32'(pmu_state), 32'd3);
      chk("wds_req", 32'(pwr_restore_req), 32'd1);

      // Save timeout.
      apply_reset();
      idle_limit = 8'd2;
      repeat (2) cycle();
      for (int i = 0; i < ACK_TIMEOUT - 1; i++) begin
         cycle();
         chk("sto_held", 32'(pwr_save_req), 32'd1);
      end
      cycle();
      chk("sto_drop", 32'(pwr_save_req), 32'd0);
      chk("sto_err", 32'(handshake_err), 32'd1);
      chk("sto_state", 32'(pmu_state), 32'd0);
      cycle();
      chk("sto_pulse", 32'(handshake_err), 32'd0);

      // Restore timeout: one low cycle then retry.
      apply_reset();
      reach_asleep();
      set_in(1'b0, 2'b00, 1'b1, 1'b1, 2'b01);
      cycle();
      set_in(1'b0, 2'b00, 1'b0, 1'b1, 2'b01);
      for (int i = 0; i < ACK_TIMEOUT - 1; i++) begin
         cycle();
         chk("rto_held", 32'(pwr_restore_req), 32'd1);
      end
      cycle();
      chk("rto_drop", 32'(pwr_restore_req), 32'd0);
      chk("rto_err", 32'(handshake_err), 32'd1);
      chk("rto_state", 32'(pmu_state), 32'd2);
      cycle();
      chk("rto_retry", 32'(pwr_restore_req), 32'd1);
      chk("rto_pulse", 32'(handshake_err), 32'd0);

      // Disable in ASLEEP requests restore.
      apply_reset();
      reach_asleep();
      cycle();
      chk("dis_stay", 32'(pmu_state), 32'd2);
      set_in(1'b0, 2'b00, 1'b0, 1'b0, 2'b01);
      cycle();
      chk("dis_rest", 32'(pwr_restore_req), 32'd1);

      // idle_limit 0 never saves.
      apply_reset();
      idle_limit = 8'd0;
      repeat (40) cycle();
      chk("lim0_state", 32'(pmu_state), 32'd0);

      // Reset mid-SAVE_REQ with a nonzero entry count.
      apply_reset();
      reach_asleep();
      set_in(1'b0, 2'b00, 1'b1, 1'b1, 2'b01);
      cycle();
      set_in(1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
      repeat (3) cycle();
      chk("mid_save", 32'(pwr_save_req), 32'd1);
      chk("mid_ent", 32'(sleep_entries), 32'd1);
      apply_reset();

      // Entry counter saturation.
      idle_limit = 8'd1;
      for (int i = 0; i < ENT_MAX + 4; i++) begin
         set_in(1'b0, 2'b00, 1'b0, 1'b1, 2'b01);
         repeat (2) cycle();
         set_in(1'b0, 2'b00, 1'b1, 1'b1, 2'b01);
         cycle();
         set_in(1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
         cycle();
      end
      chk("sat_ent", 32'(sleep_entries), 32'(ENT_MAX));

      // Random traffic against the model.
      for (int seg = 0; seg < 4; seg++) begin
         apply_reset();
         idle_limit = IDLE_W'($urandom_range(0, 5));
         for (int i = 0; i < 1000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            set_in($urandom_range(0, 99) < 25, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 96,
                   (r < 5) ? 2'b00 : ((r < 8) ? 2'b01 : 2'b10));
            cycle();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
